// File: rtl/cache_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cache_arb_pkg
//  Description : Shared types and helpers for the cache-to-memory arbiter:
//                controller state encoding, index/offset width helpers and
//                the block-base address function.
//  Revision    : 1.0 - initial release
// ============================================================================
package cache_arb_pkg;

    // Widest byte address the block_base helper handles.
    localparam int c_max_addr_w = 64;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WB   = 2'd1,
        ST_FILL = 2'd2,
        ST_DONE = 2'd3
    } arb_state_t;

    // Width of a word index within a block.
    function automatic int idx_width(input int words);
        return $clog2(words);
    endfunction

    // Number of low address bits covered by one block.
    function automatic int offset_width(input int words, input int data_w);
        return $clog2(words * (data_w / 8));
    endfunction

    // Clear the in-block byte offset of an address.
    function automatic logic [c_max_addr_w-1:0] block_base(
        input logic [c_max_addr_w-1:0] addr,
        input int                      off_w
    );
        return addr & ~((64'd1 << off_w) - 64'd1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/cache_arb_select.sv
`default_nettype none
// ============================================================================
//  Module      : cache_arb_select
//  Description : One-hot winner picker for the cache ports. Fixed priority
//                (lowest index wins) by default; with CACHE_ARB_ROUND_ROBIN_EN
//                defined the search starts at the port after the last grant
//                and a pointer register tracks that grant.
//  Revision    : 1.0 - initial release
// ============================================================================
module cache_arb_select #(
    parameter int NUM_PORTS = 2,
    parameter int SEL_W     = 1
) (
`ifdef CACHE_ARB_ROUND_ROBIN_EN
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 advance,
`endif
    input  logic [NUM_PORTS-1:0] req,
    output logic [NUM_PORTS-1:0] winner,
    output logic [SEL_W-1:0]     winner_idx
);

    logic [NUM_PORTS-1:0] w_pool;

`ifdef CACHE_ARB_ROUND_ROBIN_EN
    logic [SEL_W-1:0]     r_ptr;
    logic [NUM_PORTS-1:0] w_upper;

    // Prefer requesters above the last-granted port, else wrap to the bottom.
    always_comb begin
        w_upper = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            w_upper[i] = req[i] && (i > int'(r_ptr));
        end
        w_pool = (w_upper != '0) ? w_upper : req;
    end

    // Remember the port granted most recently.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (advance) begin
            r_ptr <= winner_idx;
        end
    end
`else
    // Fixed priority searches all requesters.
    always_comb begin
        w_pool = req;
    end
`endif

    // Lowest set bit of the candidate pool wins.
    always_comb begin
        winner     = '0;
        winner_idx = '0;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            if (w_pool[i]) begin
                winner     = '0;
                winner[i]  = 1'b1;
                winner_idx = SEL_W'(i);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/cache_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : cache_mem_arbiter
//  Description : Arbitrates block fills and dirty-block write-backs from
//                NUM_PORTS caches onto one pipelined memory port, with a
//                bounded number of outstanding reads. Optional macro
//                CACHE_ARB_ROUND_ROBIN_EN selects round-robin arbitration.
//  Revision    : 1.0 - initial release
// ============================================================================
module cache_mem_arbiter
    import cache_arb_pkg::*;
#(
    parameter int NUM_PORTS       = 2,
    parameter int DATA_W          = 16,
    parameter int ADDR_W          = 16,
    parameter int WORDS_PER_BLOCK = 8,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic [NUM_PORTS-1:0]                     req_miss,
    input  logic [NUM_PORTS-1:0]                     req_wb,
    input  logic [NUM_PORTS*ADDR_W-1:0]              req_addr,
    input  logic [NUM_PORTS*ADDR_W-1:0]              wb_addr,
    input  logic [NUM_PORTS*DATA_W-1:0]              wb_data,
    output logic [NUM_PORTS-1:0]                     grant,
    output logic [idx_width(WORDS_PER_BLOCK)-1:0]    wb_idx,
    output logic [NUM_PORTS-1:0]                     fill_valid,
    output logic [idx_width(WORDS_PER_BLOCK)-1:0]    fill_idx,
    output logic [DATA_W-1:0]                        fill_data,
    output logic [NUM_PORTS-1:0]                     done,
    output logic                                     mem_enable,
    output logic                                     mem_write_en,
    output logic [ADDR_W-1:0]                        mem_addr,
    output logic [DATA_W-1:0]                        data_to_mem,
    input  logic [DATA_W-1:0]                        data_from_mem,
    input  logic                                     mem_data_valid,
    output logic                                     hazard_stall
);

    localparam int c_idx_w = idx_width(WORDS_PER_BLOCK);
    localparam int c_cnt_w = c_idx_w + 1;
    localparam int c_bytes = DATA_W / 8;
    localparam int c_off_w = offset_width(WORDS_PER_BLOCK, DATA_W);
    localparam int c_sel_w = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    arb_state_t           r_state;
    logic [c_sel_w-1:0]   r_port;
    logic [NUM_PORTS-1:0] r_onehot;
    logic [ADDR_W-1:0]    r_wb_base;
    logic [ADDR_W-1:0]    r_fill_base;
    logic [c_cnt_w-1:0]   r_issued;
    logic [c_cnt_w-1:0]   r_recvd;
    logic [c_idx_w-1:0]   r_wb_idx;

    logic [NUM_PORTS-1:0] w_winner;
    logic [c_sel_w-1:0]   w_winner_idx;
    logic                 w_any_req;
    logic [ADDR_W-1:0]    w_win_fill_base;
    logic [ADDR_W-1:0]    w_win_wb_base;
    logic [c_cnt_w-1:0]   w_in_flight;
    logic                 w_issue_wr;
    logic                 w_issue_rd;
    logic [ADDR_W-1:0]    w_wr_addr;
    logic [ADDR_W-1:0]    w_rd_addr;

    assign w_any_req = |req_miss;

    cache_arb_select #(
        .NUM_PORTS (NUM_PORTS),
        .SEL_W     (c_sel_w)
    ) u_select (
`ifdef CACHE_ARB_ROUND_ROBIN_EN
        .clk        (clk),
        .rst        (rst),
        .advance    ((r_state == ST_IDLE) && w_any_req),
`endif
        .req        (req_miss),
        .winner     (w_winner),
        .winner_idx (w_winner_idx)
    );

    // Block bases of the winning port, latched at grant time.
    assign w_win_fill_base = ADDR_W'(block_base(
        c_max_addr_w'(req_addr[w_winner_idx*ADDR_W +: ADDR_W]), c_off_w));
    assign w_win_wb_base   = ADDR_W'(block_base(
        c_max_addr_w'(wb_addr[w_winner_idx*ADDR_W +: ADDR_W]), c_off_w));

    // Word addresses stay inside the block since the index never exceeds W-1.
    assign w_wr_addr   = r_wb_base + ADDR_W'(int'(r_wb_idx) * c_bytes);
    assign w_rd_addr   = r_fill_base + ADDR_W'(int'(r_issued) * c_bytes);

    assign w_in_flight = r_issued - r_recvd;
    assign w_issue_wr  = (r_state == ST_WB);
    assign w_issue_rd  = (r_state == ST_FILL) &&
                         (r_issued < c_cnt_w'(WORDS_PER_BLOCK)) &&
                         (w_in_flight < c_cnt_w'(MAX_OUTSTANDING));

    assign grant        = ((r_state == ST_WB) || (r_state == ST_FILL)) ? r_onehot : '0;
    assign done         = (r_state == ST_DONE) ? r_onehot : '0;
    assign mem_enable   = w_issue_wr || w_issue_rd;
    assign mem_write_en = w_issue_wr;
    assign mem_addr     = w_issue_wr ? w_wr_addr : (w_issue_rd ? w_rd_addr : '0);
    assign data_to_mem  = w_issue_wr ? wb_data[r_port*DATA_W +: DATA_W] : '0;
    assign wb_idx       = r_wb_idx;
    assign fill_valid   = ((r_state == ST_FILL) && mem_data_valid) ? r_onehot : '0;
    assign fill_idx     = r_recvd[c_idx_w-1:0];
    assign fill_data    = data_from_mem;
    assign hazard_stall = (r_state != ST_IDLE) || w_any_req;

    // Service sequencer: arbitrate, write back victim, fill block, signal done.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_port      <= '0;
            r_onehot    <= '0;
            r_wb_base   <= '0;
            r_fill_base <= '0;
            r_issued    <= '0;
            r_recvd     <= '0;
            r_wb_idx    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any_req) begin
                        r_port      <= w_winner_idx;
                        r_onehot    <= w_winner;
                        r_wb_base   <= w_win_wb_base;
                        r_fill_base <= w_win_fill_base;
                        r_state     <= req_wb[w_winner_idx] ? ST_WB : ST_FILL;
                    end
                end
                ST_WB: begin
                    r_wb_idx <= r_wb_idx + c_idx_w'(1);
                    if (r_wb_idx == c_idx_w'(WORDS_PER_BLOCK - 1)) begin
                        r_state <= ST_FILL;
                    end
                end
                ST_FILL: begin
                    if (w_issue_rd) begin
                        r_issued <= r_issued + c_cnt_w'(1);
                    end
                    if (mem_data_valid) begin
                        r_recvd <= r_recvd + c_cnt_w'(1);
                        if (r_recvd == c_cnt_w'(WORDS_PER_BLOCK - 1)) begin
                            r_state <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    r_issued <= '0;
                    r_recvd  <= '0;
                    r_wb_idx <= '0;
                    r_state  <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cache_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cache_mem_arbiter
//  Description : Self-checking bench for cache_mem_arbiter with a
//                transaction-level model and a latency-modelled memory.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cache_mem_arbiter;

    localparam int NP  = 2;
    localparam int DW  = 16;
    localparam int AW  = 16;
    localparam int WPB = 8;
    localparam int MO  = 4;
    localparam int BY  = DW / 8;

    logic clk = 1'b0;
    logic rst;
    logic [NP-1:0]    req_miss, req_wb, grant, fill_valid, done;
    logic [NP*AW-1:0] req_addr, wb_addr;
    logic [NP*DW-1:0] wb_data;
    logic [2:0]       wb_idx, fill_idx;
    logic [DW-1:0]    fill_data, data_to_mem, data_from_mem;
    logic [AW-1:0]    mem_addr;
    logic             mem_enable, mem_write_en, mem_data_valid, hazard_stall;

    always #5 clk = ~clk;

    cache_mem_arbiter #(
        .NUM_PORTS(NP), .DATA_W(DW), .ADDR_W(AW),
        .WORDS_PER_BLOCK(WPB), .MAX_OUTSTANDING(MO)
    ) dut (
        .clk(clk), .rst(rst), .req_miss(req_miss), .req_wb(req_wb),
        .req_addr(req_addr), .wb_addr(wb_addr), .wb_data(wb_data),
        .grant(grant), .wb_idx(wb_idx), .fill_valid(fill_valid),
        .fill_idx(fill_idx), .fill_data(fill_data), .done(done),
        .mem_enable(mem_enable), .mem_write_en(mem_write_en),
        .mem_addr(mem_addr), .data_to_mem(data_to_mem),
        .data_from_mem(data_from_mem), .mem_data_valid(mem_data_valid),
        .hazard_stall(hazard_stall)
    );

    function automatic logic [DW-1:0] victim_word(input int p, input int k);
        return DW'(16'hB000 + p * 16'h0100 + k * 16'h0011);
    endfunction

    function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
        return {a[7:0], a[15:8]} ^ 16'h5A3C;
    endfunction

    function automatic logic [AW-1:0] bench_base(input logic [AW-1:0] a);
        return AW'(int'(a) - (int'(a) % (WPB * BY)));
    endfunction

    // Caches drive the victim word selected by the arbiter.
    always_comb begin
        for (int p = 0; p < NP; p++) wb_data[p*DW +: DW] = victim_word(p, int'(wb_idx));
    end

    int total = 0, bad = 0, cyc = 0;
    // Model: phase 0 idle, 1 writing back, 2 filling, 3 completing.
    int mp = 0, m_port = 0, m_last = 0, m_k = 0, m_iss = 0, m_rcv = 0;
    logic [AW-1:0] m_wbbase, m_fbase;
    bit            rq[NP], rwb[NP];
    logic [AW-1:0] raddr[NP], waddr[NP];
    int            mq_ret[$];
    logic [AW-1:0] mq_addr[$];
    int            last_sched = 0, lat_min = 6, lat_max = 6;
    bit            rand_req = 0;
    logic [AW-1:0] rd_log[$], wr_log[$];
    int wbi_log[$], fi_log[$], gnt_log[$];
    int done_cyc, last_ret_cyc, first_rd_cyc, last_wr_cyc, first_gnt_cyc, max_out, n_done = 0;
    logic [NP-1:0] prev_grant = '0;

    function automatic int pick(input bit m[NP], input int last);
`ifdef CACHE_ARB_ROUND_ROBIN_EN
        for (int s = 1; s <= NP; s++) if (m[(last + s) % NP]) return (last + s) % NP;
`else
        for (int s = 0; s < NP; s++) if (m[s] && last >= 0) return s;
`endif
        return 0;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic clear_logs();
        rd_log.delete(); wr_log.delete(); wbi_log.delete(); fi_log.delete(); gnt_log.delete();
        max_out = 0; first_rd_cyc = -1; first_gnt_cyc = -1;
    endtask

    task automatic step();
        logic [NP-1:0] eg, ed, efv;
        bit erd, ewr, anyr;
        int ret, gi;
        @(negedge clk);
        cyc++;
        if (rand_req) begin
            for (int p = 0; p < NP; p++) begin
                if (!rq[p] && !(mp != 0 && m_port == p) && $urandom_range(0, 9) == 0) begin
                    rq[p] = 1; rwb[p] = 1'($urandom_range(0, 1));
                    raddr[p] = AW'($urandom); waddr[p] = AW'($urandom);
                end else if (rq[p] && mp == 2 && m_port == p && $urandom_range(0, 19) == 0) begin
                    rq[p] = 0;
                end
            end
        end
        anyr = 0;
        for (int p = 0; p < NP; p++) begin
            req_miss[p] = rq[p]; req_wb[p] = rwb[p]; anyr |= rq[p];
            req_addr[p*AW +: AW] = raddr[p]; wb_addr[p*AW +: AW] = waddr[p];
        end
        if (mq_ret.size() > 0 && mq_ret[0] <= cyc) begin
            mem_data_valid = 1; data_from_mem = mem_word(mq_addr[0]);
            void'(mq_ret.pop_front()); void'(mq_addr.pop_front()); last_ret_cyc = cyc;
        end else begin
            mem_data_valid = 0; data_from_mem = DW'($urandom);
        end
        #1;
        eg = '0; ed = '0; efv = '0;
        if (mp == 1 || mp == 2) eg[m_port] = 1'b1;
        if (mp == 3) ed[m_port] = 1'b1;
        if (mp == 2 && mem_data_valid) efv[m_port] = 1'b1;
        ewr = (mp == 1);
        erd = (mp == 2) && (m_iss < WPB) && (m_iss - m_rcv < MO);
        chk("grant", grant, eg);
        chk("done", done, ed);
        chk("fill_valid", fill_valid, efv);
        chk("mem_enable", mem_enable, ewr || erd);
        chk("mem_write_en", mem_write_en, ewr);
        chk("hazard_stall", hazard_stall, (mp != 0) || anyr);
        if (ewr) begin
            chk("wr_addr", mem_addr, m_wbbase + AW'(m_k * BY));
            chk("wb_idx", wb_idx, m_k);
            chk("data_to_mem", data_to_mem, victim_word(m_port, m_k));
        end
        if (erd) chk("rd_addr", mem_addr, m_fbase + AW'(m_iss * BY));
        if (efv != '0) begin
            chk("fill_idx", fill_idx, m_rcv);
            chk("fill_data", fill_data, mem_word(m_fbase + AW'(m_rcv * BY)));
        end
        // Observation logs and memory behaviour follow what the DUT did.
        if (grant != '0 && prev_grant == '0) begin
            gi = 0;
            for (int p = 0; p < NP; p++) if (grant[p]) gi = p;
            gnt_log.push_back(gi);
            if (first_gnt_cyc < 0) first_gnt_cyc = cyc;
        end
        prev_grant = grant;
        if (mem_enable && mem_write_en) begin
            wr_log.push_back(mem_addr); wbi_log.push_back(int'(wb_idx)); last_wr_cyc = cyc;
        end
        if (mem_enable && !mem_write_en) begin
            if (rd_log.size() == 0) first_rd_cyc = cyc;
            rd_log.push_back(mem_addr);
            ret = cyc + $urandom_range(lat_min, lat_max);
            if (ret <= last_sched) ret = last_sched + 1;
            last_sched = ret;
            mq_ret.push_back(ret); mq_addr.push_back(mem_addr);
            if (mq_ret.size() > max_out) max_out = mq_ret.size();
        end
        if (fill_valid != '0) fi_log.push_back(int'(fill_idx));
        if (done != '0) begin done_cyc = cyc; n_done++; end
        // Advance the model to the next cycle.
        case (mp)
            0: if (anyr) begin
                m_port = pick(rq, m_last); m_last = m_port;
                m_wbbase = bench_base(waddr[m_port]); m_fbase = bench_base(raddr[m_port]);
                mp = rwb[m_port] ? 1 : 2; m_k = 0; m_iss = 0; m_rcv = 0;
            end
            1: begin m_k++; if (m_k == WPB) mp = 2; end
            2: begin
                if (erd) m_iss++;
                if (mem_data_valid) m_rcv++;
                if (m_rcv == WPB) mp = 3;
            end
            default: begin rq[m_port] = 0; mp = 0; end
        endcase
    endtask

    task automatic run_until_done(input int target, input int budget);
        int n = 0;
        while (n_done < target && n < budget) begin step(); n++; end
        if (n_done < target) begin
            total++; bad++;
            $display("FAIL timeout: done count %0d required %0d", n_done, target);
        end
    endtask

    task automatic request(input int p, input logic [AW-1:0] ra, input bit wbf, input logic [AW-1:0] wa);
        rq[p] = 1; raddr[p] = ra; rwb[p] = wbf; waddr[p] = wa;
    endtask

    initial begin
        int start, n;
        rst = 1;
        for (int p = 0; p < NP; p++) begin rq[p] = 0; rwb[p] = 0; raddr[p] = '0; waddr[p] = '0; end
        req_miss = '0; req_wb = '0; req_addr = '0; wb_addr = '0;
        mem_data_valid = 0; data_from_mem = '0;
        clear_logs();
        repeat (2) step();
        chk("reset mem_addr", mem_addr, 0);
        chk("reset wb_idx", wb_idx, 0);
        chk("reset fill_idx", fill_idx, 0);
        chk("reset data_to_mem", data_to_mem, 0);
        rst = 0;

        // Simultaneous held requests straight after reset.
        clear_logs();
        request(0, 16'h3000, 0, 16'h0); request(1, 16'h5000, 0, 16'h0);
        run_until_done(n_done + 2, 400);
        chk("order count", gnt_log.size(), 2);
        if (gnt_log.size() == 2) begin
`ifdef CACHE_ARB_ROUND_ROBIN_EN
            chk("order first", gnt_log[0], 1); chk("order second", gnt_log[1], 0);
`else
            chk("order first", gnt_log[0], 0); chk("order second", gnt_log[1], 1);
`endif
        end
        step();

        // Plain fill on port 1 with a 6-cycle memory.
        clear_logs();
        request(1, 16'h1236, 0, 16'h0);
        run_until_done(n_done + 1, 200);
        chk("t1 port", (gnt_log.size() > 0) ? gnt_log[0] : -1, 1);
        chk("t1 reads", rd_log.size(), 8);
        chk("t1 fills", fi_log.size(), 8);
        if (rd_log.size() == 8 && fi_log.size() == 8) begin
            chk("t1 first rd", rd_log[0], 16'h1230);
            chk("t1 last rd", rd_log[7], 16'h123E);
            chk("t1 last idx", fi_log[7], 7);
        end
        chk("t1 done latency", done_cyc, last_ret_cyc + 1);
        chk("t1 max outstanding", max_out, 4);
        step();

        // Write-back then fill on port 0.
        clear_logs();
        start = cyc;
        request(0, 16'h8004, 1, 16'h4000);
        run_until_done(n_done + 1, 200);
        chk("t2 grant latency", first_gnt_cyc, start + 2);
        chk("t2 writes", wr_log.size(), 8);
        chk("t2 reads", rd_log.size(), 8);
        if (wr_log.size() == 8 && rd_log.size() == 8) begin
            chk("t2 first wr", wr_log[0], 16'h4000);
            chk("t2 last wr", wr_log[7], 16'h400E);
            chk("t2 last wb_idx", wbi_log[7], 7);
            chk("t2 first rd", rd_log[0], 16'h8000);
            chk("t2 last rd", rd_log[7], 16'h800E);
        end
        chk("t2 wb to fill", first_rd_cyc, last_wr_cyc + 1);
        step();

        // Top-of-memory block does not wrap.
        clear_logs();
        request(0, 16'hFFFE, 0, 16'h0);
        run_until_done(n_done + 1, 200);
        if (rd_log.size() == 8) begin
            chk("t6 first rd", rd_log[0], 16'hFFF0);
            chk("t6 last rd", rd_log[7], 16'hFFFE);
        end else chk("t6 reads", rd_log.size(), 8);
        step();

        // Reset during a fill after three returns.
        request(0, 16'h2000, 0, 16'h0);
        n = 0;
        while (!(mp == 2 && m_rcv == 3) && n < 100) begin step(); n++; end
        chk("t5 reached 3 returns", m_rcv, 3);
        @(posedge clk); #3;
        rst = 1;
        for (int p = 0; p < NP; p++) rq[p] = 0;
        req_miss = '0;
        #1;
        chk("t5 grant", grant, 0);
        chk("t5 mem_enable", mem_enable, 0);
        chk("t5 mem_write_en", mem_write_en, 0);
        chk("t5 fill_valid", fill_valid, 0);
        chk("t5 done", done, 0);
        chk("t5 hazard", hazard_stall, 0);
        chk("t5 mem_addr", mem_addr, 0);
        chk("t5 fill_idx", fill_idx, 0);
        mp = 0; m_last = 0; m_iss = 0; m_rcv = 0; m_k = 0;
        repeat (2) step();
        rst = 0;
        repeat (12) step();

        // Randomised traffic with variable latency.
        lat_min = 1; lat_max = 7; rand_req = 1;
        repeat (3000) step();
        rand_req = 0;
        n = 0;
        while ((mp != 0 || rq[0] || rq[1] || mq_ret.size() != 0) && n < 600) begin step(); n++; end
        if (n >= 600) begin
            total++; bad++;
            $display("FAIL drain timeout: phase %0d", mp);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cache_mem_arbiter.md
# cache_mem_arbiter

Parametrised cache-to-memory controller arbitrating block fills and dirty-block write-backs from `NUM_PORTS` cache ports onto one pipelined memory port. Generalises the fixed two-cache (I/D), 8-word, 16-bit miss FSM to N ports, configurable block depth and data/address width, and a bounded number of outstanding reads. It sits between the L1 caches and unified memory, and drives the pipeline stall.

## Interface
- `NUM_PORTS`, 2: requesting caches (1..8); lower index = higher fixed priority.
- `DATA_W`, 16: memory word width in bits, multiple of 8.
- `ADDR_W`, 16: byte-address width.
- `WORDS_PER_BLOCK`, 8: words per block, power of two, ≥2.
- `MAX_OUTSTANDING`, 4: maximum issued-but-unreturned reads (1..`WORDS_PER_BLOCK`).
- `clk` in 1: the only clock; all state on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req_miss` in `NUM_PORTS`: per-port fill request, level, held until `done`.
- `req_wb` in `NUM_PORTS`: a dirty victim must be written back before the fill; sampled with `req_miss`.
- `req_addr` in `NUM_PORTS*ADDR_W`: miss byte address; block offset ignored.
- `wb_addr` in `NUM_PORTS*ADDR_W`: victim byte address; block offset ignored.
- `wb_data` in `NUM_PORTS*DATA_W`: victim word at index `wb_idx`, combinational from port.
- `grant` out `NUM_PORTS`: one-hot, port under service.
- `wb_idx` out `IDX_W`: victim word index being written this cycle.
- `fill_valid` out `NUM_PORTS`: returned fill word for that port.
- `fill_idx` out `IDX_W`: word index of `fill_data`.
- `fill_data` out `DATA_W`: equals `data_from_mem`.
- `done` out `NUM_PORTS`: one-cycle pulse, service complete.
- `mem_enable` out 1: memory access issued this cycle.
- `mem_write_en` out 1: issued access is a write.
- `mem_addr` out `ADDR_W`: access byte address.
- `data_to_mem` out `DATA_W`: write data.
- `data_from_mem` in `DATA_W`: read return data.
- `mem_data_valid` in 1: read return strobe, in-order.
- `hazard_stall` out 1: stall pipeline.

## Operation
- `IDX_W = $clog2(WORDS_PER_BLOCK)`, `BYTES = DATA_W/8`; block base = address with low `$clog2(WORDS_PER_BLOCK*BYTES)` bits cleared; word k address = base + k*BYTES, modulo 2^ADDR_W.
- States: IDLE, WB, FILL, DONE.
- IDLE: if any `req_miss`, pick winner; latch port, `req_wb`, both bases; go WB if `req_wb` else FILL.
- WB: one write per cycle for k = 0..W-1: `mem_enable=mem_write_en=1`, `mem_addr` = victim word k, `wb_idx=k`, `data_to_mem` = granted `wb_data`. After k=W-1, go FILL.
- FILL: counters `issued`, `recvd` (IDX_W+1 bits). Issue read (`mem_enable=1`, `mem_write_en=0`, `mem_addr` = word `issued`) when `issued<W` and `issued-recvd<MAX_OUTSTANDING`. Each `mem_data_valid`: `fill_valid[grant]=1`, `fill_idx=recvd`, `recvd++`. Issue and return may coincide. When `recvd` reaches W, go DONE.
- DONE: `done[grant]=1` for one cycle; then IDLE. Counters cleared.
- `mem_data_valid` outside FILL is ignored (no `fill_valid`).
- `req_miss` dropped mid-service: service still completes.
- `hazard_stall` = state≠IDLE or any `req_miss`.

## Timing
- Reset values: state IDLE, counters 0, `grant`, `fill_valid`, `done`, `mem_enable`, `mem_write_en`, `hazard_stall` 0; `mem_addr`, `data_to_mem`, `wb_idx`, `fill_idx` 0; RR pointer 0.
- Request seen at edge N → `grant` and first WB/FILL cycle from N+1.
- WB lasts exactly W cycles; first read issues in the first FILL cycle.
- `done` is asserted the cycle after the W-th return; `grant` drops with it. Next arbitration occurs in the following IDLE cycle (minimum one idle cycle between services).
- Reset mid-operation: immediate return to IDLE; subsequent in-flight returns are ignored.

## Configuration
- `CACHE_ARB_ROUND_ROBIN_EN` defined: round-robin; search starts at the port after the last-granted one; pointer updated at grant.
- Undefined: fixed priority, lowest index wins; no pointer register.

## Structure
- `cache_arb_pkg`: state enum, `IDX_W`/offset-width helper functions, `block_base` function.
- Sub-module `cache_arb_select`: one-hot winner picker (fixed or round-robin, carries the macro).

## Test plan
- Defaults; port1 `req_miss`, `req_addr=0x1236` → grant=10, reads 0x1230..0x123E, 8 `fill_valid` with idx 0..7, `done[1]` one cycle after 8th return.
- Port0 `req_wb`, `wb_addr=0x4000`, `req_addr=0x8004` → 8 writes 0x4000..0x400E with `wb_idx` 0..7, then reads 0x8000..0x800E.
- Memory latency 6 cycles → never more than 4 reads outstanding; issue stalls at `issued-recvd=4`.
- Both ports request together, held: fixed → 0 then 1; with macro and pointer at 0 → 1 then 0.
- `rst` asserted during FILL after 3 returns → all outputs 0 immediately; late `mem_data_valid` produces no `fill_valid`.
- `req_addr=0xFFFE` (`ADDR_W=16`) → base 0xFFF0, last read 0xFFFE; no wrap past block.
